// File: rtl/fb_pkg.sv
// Shared definitions for the character framebuffer: geometry, cell word layout
// and the write-scheduler state encoding.
package fb_pkg;

   localparam int COLS  = 80;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;
   localparam int AW    = 12;
   localparam int DW    = 11;

   // cell word = {colour[2:0], char[7:0]}
   localparam int CHAR_LSB   = 0;
   localparam int CHAR_W     = 8;
   localparam int COLOUR_LSB = CHAR_LSB + CHAR_W;
   localparam int COLOUR_W   = 3;

   localparam logic [DW-1:0] CLEAR_WORD = 11'h020;
   localparam logic [AW-1:0] LAST_CELL  = AW'(CELLS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_CLEAR  = 2'd2
   } fb_state_e;

   function automatic logic cell_in_range(input logic [AW-1:0] addr);
      return addr < AW'(CELLS);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the other side whenever a
// grant is given, so a lone requester also hands priority away.
module rr_arbiter2 (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   logic ptr_b;

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (en) begin
         if (req_a && req_b) begin
            gnt_a = !ptr_b;
            gnt_b = ptr_b;
         end else begin
            gnt_a = req_a;
            gnt_b = req_b;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         ptr_b <= 1'b0;
      else if (gnt_a)
         ptr_b <= 1'b1;
      else if (gnt_b)
         ptr_b <= 1'b0;
   end

endmodule

// File: rtl/fb_write_scheduler.sv
// Schedules framebuffer writes from two requesters and the clear engine,
// issuing them only during vertical blanking.
//
// state  | meaning
// IDLE   | active video, no writes, readys low
// ACTIVE | vblank, serving port A / port B round-robin
// CLEAR  | vblank, sweeping CLEAR_WORD over all cells from clr_addr
module fb_write_scheduler
   import fb_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          vblank,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   input  logic          clear_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          busy,
   output logic          clear_done,
   output logic          err_oob
);

   fb_state_e     state, state_nxt;
   logic          clear_pend;
   logic [AW-1:0] clr_addr;

   logic          serve_en;
   logic          a_fire, b_fire, req_fire;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          clr_wr, clr_last;
   logic          wr_en, oob;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   // Holding readys low while a clear is pending lets the sweep start cleanly.
   assign serve_en = (state == ST_ACTIVE) && vblank && !clear_pend;

   rr_arbiter2 u_arb (
      .clock (clock),
      .reset (reset),
      .en    (serve_en),
      .req_a (a_valid),
      .req_b (b_valid),
      .gnt_a (a_ready),
      .gnt_b (b_ready)
   );

   always_comb begin
      a_fire    = a_valid && a_ready;
      b_fire    = b_valid && b_ready;
      req_fire  = a_fire || b_fire;
      req_addr  = a_fire ? a_addr : b_addr;
      req_data  = a_fire ? a_data : b_data;
      clr_wr    = (state == ST_CLEAR) && vblank;
      clr_last  = clr_wr && (clr_addr == LAST_CELL);
      oob       = req_fire && !cell_in_range(req_addr);
      wr_en     = clr_wr || (req_fire && cell_in_range(req_addr));
      wr_addr   = clr_wr ? clr_addr : req_addr;
      wr_data   = clr_wr ? CLEAR_WORD : req_data;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (vblank)
               state_nxt = clear_pend ? ST_CLEAR : ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!vblank)
               state_nxt = ST_IDLE;
            else if (clear_pend)
               state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (!vblank)
               state_nxt = ST_IDLE;
            else if (clr_last)
               state_nxt = ST_ACTIVE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // A clear request landing on the final sweep write re-arms one more sweep.
   always_ff @(posedge clock) begin
      if (reset) begin
         clear_pend <= 1'b0;
         clr_addr   <= '0;
      end else begin
         if (clr_last)
            clear_pend <= clear_req;
         else if (clear_req)
            clear_pend <= 1'b1;

         if (clr_last)
            clr_addr <= '0;
         else if (clr_wr)
            clr_addr <= clr_addr + AW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         clear_done <= 1'b0;
         err_oob    <= 1'b0;
      end else begin
         mem_we     <= wr_en;
         clear_done <= clr_last;
         err_oob    <= oob;
         if (wr_en) begin
            mem_addr <= wr_addr;
            mem_data <= wr_data;
         end
      end
   end

   assign busy = clear_pend;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: port writes, round-robin, clear
// sweeps with blanking interruption, out-of-range drop and mid-sweep reset.
module tb_fb_write_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        vblank;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [11:0] a_addr, b_addr;
   logic [10:0] a_data, b_data;
   logic        clear_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [10:0] mem_data;
   logic        busy, clear_done, err_oob;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   fb_write_scheduler dut (
      .clock      (clock),
      .reset      (reset),
      .vblank     (vblank),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_addr     (a_addr),
      .a_data     (a_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_addr     (b_addr),
      .b_data     (b_data),
      .clear_req  (clear_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .busy       (busy),
      .clear_done (clear_done),
      .err_oob    (err_oob)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
   endtask

   // Observe clear writes until clear_done or the cycle budget runs out.
   task automatic watch_sweep(input int budget, input logic [11:0] start,
                              output int nwr, output int bad, output int gaps,
                              output int rdy_bad, output logic done_seen,
                              output logic [11:0] done_addr);
      logic [11:0] exp_addr;
      exp_addr  = start;
      nwr       = 0;
      bad       = 0;
      gaps      = 0;
      rdy_bad   = 0;
      done_seen = 1'b0;
      done_addr = '0;
      for (int i = 0; i < budget && !done_seen; i++) begin
         if (busy && (a_ready || b_ready)) rdy_bad++;
         tick();
         if (mem_we) begin
            if (mem_addr !== exp_addr || mem_data !== 11'h020) bad++;
            exp_addr = exp_addr + 12'd1;
            nwr++;
         end else if (nwr > 0) begin
            gaps++;
         end
         if (clear_done) begin
            done_seen = 1'b1;
            done_addr = mem_addr;
            a_valid   = 1'b0;
         end
      end
   endtask

   int          nwr, bad, gaps, rdy_bad, idle_we;
   logic        done_seen;
   logic [11:0] done_addr;

   initial begin
      reset = 1'b1; vblank = 1'b0; clear_req = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      do_reset();

      // reset state
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_clear_done", clear_done, 0);
      chk("rst_err_oob", err_oob, 0);
      chk("rst_b_ready", b_ready, 0);

      // port A write held off until vblank
      a_valid = 1'b1; a_addr = 12'd5; a_data = 11'h141;
      #1;
      chk("a_ready_no_vblank", a_ready, 0);
      tick(); tick();
      chk("a_ready_no_vblank2", a_ready, 0);
      chk("no_we_no_vblank", mem_we, 0);
      vblank = 1'b1;
      tick();
      chk("a_ready_vblank", a_ready, 1);
      tick();
      a_valid = 1'b0;
      chk("a_we", mem_we, 1);
      chk("a_addr", mem_addr, 5);
      chk("a_data", mem_data, 11'h141);
      tick();
      chk("a_we_after", mem_we, 0);

      // round-robin A,B,A,B,A,B from a fresh pointer
      do_reset();
      tick();
      a_valid = 1'b1; a_addr = 12'd10; a_data = 11'h111;
      b_valid = 1'b1; b_addr = 12'd20; b_data = 11'h222;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rr_a_ready_%0d", i), a_ready, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("rr_b_ready_%0d", i), b_ready, (i % 2 == 1) ? 1 : 0);
         tick();
         chk($sformatf("rr_we_%0d", i), mem_we, 1);
         chk($sformatf("rr_addr_%0d", i), mem_addr, (i % 2 == 0) ? 10 : 20);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
      chk("rr_we_idle", mem_we, 0);

      // full clear in one blanking interval, port A kept requesting
      pulse_clear();
      chk("clr_busy_set", busy, 1);
      a_valid = 1'b1; a_addr = 12'd7; a_data = 11'h077;
      #1;
      watch_sweep(3000, 12'd0, nwr, bad, gaps, rdy_bad, done_seen, done_addr);
      chk("clr_done_seen", done_seen, 1);
      chk("clr_nwr", nwr, 2400);
      chk("clr_bad_words", bad, 0);
      chk("clr_gaps", gaps, 0);
      chk("clr_readys_low", rdy_bad, 0);
      chk("clr_done_addr", done_addr, 2399);
      chk("clr_busy_clr", busy, 0);
      tick();
      chk("clr_we_after", mem_we, 0);
      chk("clr_done_pulse", clear_done, 0);

      // clear interrupted by end of blanking after 1000 writes
      pulse_clear();
      nwr = 0;
      for (int i = 0; i < 1200 && nwr < 1000; i++) begin
         tick();
         if (mem_we) nwr++;
      end
      vblank = 1'b0;
      chk("part_nwr", nwr, 1000);
      chk("part_last_addr", mem_addr, 999);
      idle_we = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mem_we) idle_we++;
      end
      chk("part_no_writes", idle_we, 0);
      chk("part_busy_held", busy, 1);
      vblank = 1'b1;
      watch_sweep(2000, 12'd1000, nwr, bad, gaps, rdy_bad, done_seen, done_addr);
      chk("resume_done_seen", done_seen, 1);
      chk("resume_nwr", nwr, 1400);
      chk("resume_bad_words", bad, 0);
      chk("resume_done_addr", done_addr, 2399);
      chk("resume_busy_clr", busy, 0);
      tick();

      // out-of-range drop, then the last legal cell
      b_valid = 1'b1; b_addr = 12'd2400; b_data = 11'h3ff;
      #1;
      chk("oob_b_ready", b_ready, 1);
      tick();
      b_valid = 1'b0;
      chk("oob_no_we", mem_we, 0);
      chk("oob_err", err_oob, 1);
      tick();
      chk("oob_err_once", err_oob, 0);
      b_valid = 1'b1; b_addr = 12'd2399; b_data = 11'h155;
      tick();
      b_valid = 1'b0;
      chk("last_cell_we", mem_we, 1);
      chk("last_cell_addr", mem_addr, 2399);
      chk("last_cell_err", err_oob, 0);
      tick();

      // reset during a sweep abandons it
      pulse_clear();
      nwr = 0;
      for (int i = 0; i < 900 && nwr < 700; i++) begin
         tick();
         if (mem_we) nwr++;
      end
      chk("rstclr_nwr", nwr, 700);
      reset = 1'b1;
      tick();
      chk("rstclr_we", mem_we, 0);
      chk("rstclr_addr", mem_addr, 0);
      chk("rstclr_data", mem_data, 0);
      chk("rstclr_busy", busy, 0);
      chk("rstclr_done", clear_done, 0);
      chk("rstclr_err", err_oob, 0);
      vblank = 1'b0;
      reset = 1'b0;
      tick(); tick(); tick();
      vblank = 1'b1;
      idle_we = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_we) idle_we++;
      end
      chk("rstclr_no_sweep", idle_we, 0);
      chk("rstclr_busy_low", busy, 0);
      a_valid = 1'b1; a_addr = 12'd33; a_data = 11'h055;
      #1;
      chk("rstclr_a_ready", a_ready, 1);
      tick();
      a_valid = 1'b0;
      chk("rstclr_a_we", mem_we, 1);
      chk("rstclr_a_addr", mem_addr, 33);
      chk("rstclr_a_data", mem_data, 11'h055);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
